// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: two write ports, two read ports, clear request and status.
interface reg_file_mp_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         write_en0;
  logic [D-1:0] waddr0;
  logic [W-1:0] data_in0;
  logic         write_en1;
  logic [D-1:0] waddr1;
  logic [W-1:0] data_in1;
  logic [D-1:0] raddrA;
  logic [D-1:0] raddrB;
  logic [W-1:0] data_outA;
  logic [W-1:0] data_outB;
  logic         clr_req;
  logic         busy;
  logic         wr_conflict;

  modport master (
    output write_en0, waddr0, data_in0,
    output write_en1, waddr1, data_in1,
    output raddrA, raddrB, clr_req,
    input  data_outA, data_outB, busy, wr_conflict
  );

  modport slave (
    input  write_en0, waddr0, data_in0,
    input  write_en1, waddr1, data_in1,
    input  raddrA, raddrB, clr_req,
    output data_outA, data_outB, busy, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// 2-write/2-read register file with a clear sweep after reset or on request.
// Reads are combinational (optional write bypass); writes and the sweep land on the CLK edge.
module reg_file_mp #(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic          CLK,
  input logic          reset,
  reg_file_mp_if.slave bus
);
  localparam int           DEPTH = 1 << D;
  localparam logic [D-1:0] LAST  = {D{1'b1}};

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t       state, state_d;
  logic [D-1:0] ptr, ptr_d;
  logic         wr_conflict_q, conflict_d;
  logic         we0, we1;
  logic [W-1:0] mem [DEPTH];

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    we0        = 1'b0;
    we1        = 1'b0;
    conflict_d = 1'b0;
    if (state == CLEAR) begin
      ptr_d = ptr + 1'b1;
      if (ptr == LAST) state_d = IDLE;
    end else begin
      // Address-0 writes are dropped up front so they can neither land nor raise a conflict.
      we0 = bus.write_en0 && !(ZERO_REG != 0 && bus.waddr0 == '0);
      we1 = bus.write_en1 && !(ZERO_REG != 0 && bus.waddr1 == '0);
      conflict_d = we0 && we1 && (bus.waddr0 == bus.waddr1);
      if (bus.clr_req) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= CLEAR;
      ptr           <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      wr_conflict_q <= conflict_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      mem[0] <= '0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      if (we0) mem[bus.waddr0] <= bus.data_in0;
      if (we1) mem[bus.waddr1] <= bus.data_in1;
    end
  end

  function automatic logic [W-1:0] rd(input logic [D-1:0] a);
    logic [W-1:0] v;
    v = mem[a];
    if (BYPASS != 0 && we0 && bus.waddr0 == a) v = bus.data_in0;
    if (BYPASS != 0 && we1 && bus.waddr1 == a) v = bus.data_in1;
    if (state == CLEAR || (ZERO_REG != 0 && a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    bus.data_outA = rd(bus.raddrA);
    bus.data_outB = rd(bus.raddrB);
  end

  assign bus.busy        = (state == CLEAR);
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: ZERO_REG=0 and ZERO_REG=1 instances share stimulus and a per-instance model.
module tb_reg_file_mp;
  logic       CLK = 1'b0;
  logic       rst;
  logic       we0, we1, clr;
  logic [2:0] wa0, wa1, ra, rb;
  logic [7:0] di0, di1;

  int total = 0;
  int bad   = 0;

  reg_file_mp_if #(.W(8), .D(3)) b0 ();
  reg_file_mp_if #(.W(8), .D(3)) b1 ();

  reg_file_mp #(.W(8), .D(3), .ZERO_REG(0), .BYPASS(1)) u0 (.CLK(CLK), .reset(rst), .bus(b0));
  reg_file_mp #(.W(8), .D(3), .ZERO_REG(1), .BYPASS(1)) u1 (.CLK(CLK), .reset(rst), .bus(b1));

  assign b0.write_en0 = we0; assign b1.write_en0 = we0;
  assign b0.waddr0    = wa0; assign b1.waddr0    = wa0;
  assign b0.data_in0  = di0; assign b1.data_in0  = di0;
  assign b0.write_en1 = we1; assign b1.write_en1 = we1;
  assign b0.waddr1    = wa1; assign b1.waddr1    = wa1;
  assign b0.data_in1  = di1; assign b1.data_in1  = di1;
  assign b0.raddrA    = ra;  assign b1.raddrA    = ra;
  assign b0.raddrB    = rb;  assign b1.raddrB    = rb;
  assign b0.clr_req   = clr; assign b1.clr_req   = clr;

  logic [7:0] oa [2];
  logic [7:0] ob [2];
  logic       bsy [2];
  logic       cf [2];
  assign oa[0] = b0.data_outA; assign oa[1] = b1.data_outA;
  assign ob[0] = b0.data_outB; assign ob[1] = b1.data_outB;
  assign bsy[0] = b0.busy;     assign bsy[1] = b1.busy;
  assign cf[0] = b0.wr_conflict; assign cf[1] = b1.wr_conflict;

  always #5 CLK = ~CLK;

  // Model: remaining sweep cycles instead of a pointer; memory zeroed when the sweep completes.
  logic       valid = 1'b0;
  int         left = 0;
  logic [7:0] mm [2][8];
  logic       mcf [2];

  function automatic logic dropped(input int z, input logic [2:0] a);
    return (z == 1) && (a == 3'd0);
  endfunction

  always @(posedge CLK) begin
    if (rst) begin
      valid = 1'b1;
      left  = 8;
      for (int z = 0; z < 2; z++) begin mm[z][0] = 8'h00; mcf[z] = 1'b0; end
    end else if (valid) begin
      if (left > 0) begin
        left = left - 1;
        for (int z = 0; z < 2; z++) begin
          mcf[z] = 1'b0;
          if (left == 0) for (int a = 0; a < 8; a++) mm[z][a] = 8'h00;
        end
      end else begin
        for (int z = 0; z < 2; z++) begin
          if (we0 && !dropped(z, wa0)) mm[z][wa0] = di0;
          if (we1 && !dropped(z, wa1)) mm[z][wa1] = di1;
          mcf[z] = we0 && we1 && (wa0 == wa1) && !dropped(z, wa0);
        end
        if (clr) left = 8;
      end
    end
  end

  function automatic logic [7:0] exp_rd(input int z, input logic [2:0] a);
    if (left > 0 || dropped(z, a)) return 8'h00;
    if (we1 && wa1 == a) return di1;
    if (we0 && wa0 == a) return di0;
    return mm[z][a];
  endfunction

  // Length of the most recent completed busy run, restarted by reset.
  int run = 0, last_run = 0, runs_done = 0;
  always @(negedge CLK) begin
    if (rst) run = 0;
    else if (bsy[0]) run = run + 1;
    else if (run > 0) begin last_run = run; runs_done = runs_done + 1; run = 0; end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    if (valid) begin
      for (int z = 0; z < 2; z++) begin
        chk($sformatf("busy[%0d]", z), 32'(bsy[z]), 32'(left > 0));
        chk($sformatf("conflict[%0d]", z), 32'(cf[z]), 32'(mcf[z]));
        chk($sformatf("outA[%0d]@%0d", z, ra), 32'(oa[z]), 32'(exp_rd(z, ra)));
        chk($sformatf("outB[%0d]@%0d", z, rb), 32'(ob[z]), 32'(exp_rd(z, rb)));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    we0 = 0; we1 = 0; clr = 0;
    wa0 = 0; wa1 = 0; di0 = 0; di1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int rd0;

  initial begin
    quiet();
    ra = 0; rb = 0;
    rst = 1;
    we0 = 1; wa0 = 3; di0 = 8'h99;
    step();
    chk("reset busy", 32'(bsy[0]), 32'd1);
    chk("reset conflict", 32'(cf[0]), 32'd0);
    chk("reset outA", 32'(oa[0]), 32'd0);
    step();
    step();
    rst = 0;
    wa0 = 4; di0 = 8'h33;
    rd0 = runs_done;
    for (int i = 0; i < 8; i++) step();
    we0 = 0;
    step();
    chk("sweep length after reset", 32'(last_run), 32'd8);
    chk("sweep runs after reset", 32'(runs_done - rd0), 32'd1);
    for (int i = 0; i < 8; i++) begin ra = 3'(i); rb = 3'(7 - i); step(); end
    ra = 4; #1;
    chk("write during sweep lost", 32'(oa[0]), 32'h00);

    we0 = 1; wa0 = 3; di0 = 8'h5A;
    step();
    we0 = 0; ra = 3; #1;
    chk("read addr3", 32'(oa[0]), 32'h5A);
    we1 = 1; wa1 = 5; di1 = 8'h77; rb = 5; #1;
    chk("bypass outB", 32'(ob[0]), 32'h77);
    step();
    we1 = 0;
    step();

    we0 = 1; wa0 = 2; di0 = 8'h11;
    we1 = 1; wa1 = 2; di1 = 8'h22;
    step();
    we0 = 0; we1 = 0; ra = 2; #1;
    chk("conflict winner", 32'(oa[0]), 32'h22);
    chk("conflict pulse", 32'(cf[0]), 32'd1);
    step();
    chk("conflict cleared", 32'(cf[0]), 32'd0);

    we0 = 1; wa0 = 0; di0 = 8'hFF;
    step();
    we0 = 0; ra = 0; #1;
    chk("zero_reg read", 32'(oa[1]), 32'h00);
    chk("plain addr0 read", 32'(oa[0]), 32'hFF);
    we0 = 1; wa0 = 0; di0 = 8'h01; we1 = 1; wa1 = 0; di1 = 8'h02;
    step();
    quiet(); #1;
    chk("zero_reg no conflict", 32'(cf[1]), 32'd0);
    chk("addr0 conflict", 32'(cf[0]), 32'd1);
    step();

    for (int i = 0; i < 8; i++) begin we0 = 1; wa0 = 3'(i); di0 = 8'hAA; ra = 3'(i); step(); end
    we0 = 0; ra = 7; rb = 0; #1;
    chk("fill addr7", 32'(oa[0]), 32'hAA);
    chk("fill addr0 zero_reg", 32'(ob[1]), 32'h00);
    rd0 = runs_done;
    clr = 1;
    step();
    clr = 0;
    step(); step(); step();
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 5; i++) step();
    chk("clear sweep length", 32'(last_run), 32'd8);
    chk("clear sweep runs", 32'(runs_done - rd0), 32'd1);
    for (int i = 0; i < 8; i++) begin ra = 3'(i); rb = 3'(i); step(); end
    ra = 7; #1;
    chk("cleared addr7", 32'(oa[0]), 32'h00);

    rd0 = runs_done;
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    step();
    rst = 0;
    chk("busy after mid reset", 32'(bsy[0]), 32'd1);
    for (int i = 0; i < 9; i++) step();
    chk("restarted sweep length", 32'(last_run), 32'd8);
    chk("restarted sweep runs", 32'(runs_done - rd0), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter W, default 8, the data width in bits.
REQ-002 The block SHALL have parameter D, default 3, the address width; depth is 2**D entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, entry 0 reads as zero and writes to it are discarded.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have ports write_en0 (input, 1), waddr0 (input, D) and data_in0 (input, W), forming write port 0.
REQ-008 The block SHALL have ports write_en1 (input, 1), waddr1 (input, D) and data_in1 (input, W), forming write port 1.
REQ-009 The block SHALL have ports raddrA and raddrB (input, D each), the read addresses.
REQ-010 The block SHALL have ports data_outA and data_outB (output, W each), the combinational read data.
REQ-011 The block SHALL have port clr_req, input, 1 bit, a request to start a clear sweep.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a clear sweep is in progress.
REQ-013 The block SHALL have port wr_conflict, output, 1 bit, a registered one-cycle pulse flagging a dual write to the same address.

Function
REQ-014 The FSM SHALL have two states: CLEAR and IDLE. It SHALL also hold a D-bit sweep pointer ptr.
REQ-015 Writing SHALL happen in IDLE only; each enabled port SHALL write its data at waddr on the clock edge.
REQ-016 When both ports are enabled with the same waddr, port 1 SHALL win; on the next cycle wr_conflict SHALL be 1, and 0 otherwise.
REQ-017 When ZERO_REG=1, writes to address 0 SHALL be discarded, a same-address conflict at address 0 SHALL NOT be flagged, and reads of address 0 SHALL return 0.
REQ-018 In IDLE, a read SHALL return the stored entry. When BYPASS=1 and an enabled port writes the read address in the same cycle, the read SHALL return that port's data instead, with port 1 taking precedence.
REQ-019 In CLEAR, each cycle SHALL write 0 to entry ptr and then increment ptr. When ptr = 2**D-1 the FSM SHALL write that entry and move to IDLE.
REQ-020 Both write ports SHALL be ignored in CLEAR, including the cycle the FSM leaves CLEAR; wr_conflict SHALL stay 0.
REQ-021 In CLEAR, data_outA and data_outB SHALL read 0, with no bypass.
REQ-022 busy SHALL be 1 exactly when the state is CLEAR.
REQ-023 clr_req=1 in IDLE SHALL move the FSM to CLEAR with ptr=0 on the next edge; that cycle's writes SHALL still complete.
REQ-024 clr_req SHALL be ignored in CLEAR.
REQ-025 When the FSM passes ptr = 2**D-1, ptr SHALL wrap to 0, and no address outside 0..2**D-1 SHALL be written.

Reset
REQ-026 While reset=1 at an edge, the next state SHALL be CLEAR with ptr=0, wr_conflict=0, and entry 0 written to 0; all write ports and clr_req SHALL be ignored.
REQ-027 Once reset is released, busy SHALL stay 1 for exactly 2**D further cycles, and the first write SHALL be accepted on the following edge.
REQ-028 Reset asserted in the middle of a sweep SHALL restart the sweep at ptr=0.
REQ-029 All outputs SHALL be 0 from the first reset edge onward, except busy, which SHALL be 1.

Verification (W=8, D=3)
REQ-030 Reset and sweep: hold reset for 2 cycles, then release -> busy=1 for 8 cycles, then 0; every address reads 0x00; writes attempted during the sweep are lost.
REQ-031 Write and read: port 0 writes 0x5A to address 3, then raddrA=3 -> 0x5A. With BYPASS=1, same-cycle write of 0x77 to address 5 with raddrB=5 -> data_outB=0x77 in that same cycle.
REQ-032 Conflict: both ports write address 2, with 0x11 on port 0 and 0x22 on port 1 -> address 2 holds 0x22, and wr_conflict=1 for exactly one cycle.
REQ-033 ZERO_REG=1: write 0xFF to address 0 -> reads 0x00 and wr_conflict stays 0. ZERO_REG=0 -> reads 0xFF.
REQ-034 clr_req after filling all entries with 0xAA -> busy=1 for 8 cycles, after which all entries read 0x00. A second clr_req during the sweep does not extend it.
REQ-035 Reset mid-sweep: assert reset at ptr=5 -> sweep restarts at 0, and busy stays 1 for 8 cycles after release.
